c_seq_gen_control: RTL and testbench

- Controller wrapped around a 3GPP TS 38.211 §5.2.1 length-31 Gold-sequence generator. Produces c(n) as nGenBit-bit words, one word per clock.
- After i_start it fast-forwards past the Nc=1600 warm-up bits plus i_threshold words, then streams words to a consumer through a valid/get handshake.
- Used by the PUCCH chain, e.g. cyclic-shift hopping n_cs(nslot, l) with i_threshold = 14*nslot.

---
 rtl/c_seq_gen_control.sv | 136 +++++++++++++
 tb/tb_c_seq_gen_control.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/c_seq_gen_control.sv
// Length-31 Gold-sequence generator with warm-up/skip control and a valid/get
// word stream; each clock advances both LFSRs by nGenBit bits when enabled.
//
// state  | meaning
// IDLE   | nothing loaded since reset, outputs quiet
// WARMUP | discarding the 1600 warm-up bits, nGenBit per cycle
// SKIP   | discarding threshold words after the warm-up
// READY  | word stream available, one word popped per i_get
module c_seq_gen_control #(
  parameter int nGenBit = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_get,
  input  logic [30:0]        i_init,
  input  logic [15:0]        i_threshold,
  output logic [nGenBit-1:0] o_gen_bit,
  output logic               o_valid,
  output logic               o_gen_done
);

  localparam int          WARM_CYC  = 1600 / nGenBit;
  localparam logic [15:0] WARM_LAST = 16'(WARM_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    SKIP   = 2'd2,
    READY  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [30:0] x1_q, x2_q;
  logic [15:0] cnt_q, cnt_nxt;
  logic [15:0] thr_q;
  logic [15:0] get_count_q;
  logic        load, adv, take;

  // Bit i of each vector is x(n+i); bits 31 and up are the next nGenBit terms.
  logic [30+nGenBit:0] x1_ext, x2_ext;

  always_comb begin
    x1_ext        = '0;
    x2_ext        = '0;
    x1_ext[30:0]  = x1_q;
    x2_ext[30:0]  = x2_q;
    for (int i = 0; i < nGenBit; i++) begin
      x1_ext[i+31] = x1_ext[i+3] ^ x1_ext[i];
      x2_ext[i+31] = x2_ext[i+3] ^ x2_ext[i+2] ^ x2_ext[i+1] ^ x2_ext[i];
    end
  end

  // Next-state, down-counter and advance enables; i_start overrides all states.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    load      = 1'b0;
    adv       = 1'b0;
    take      = 1'b0;
    if (i_start) begin
      load      = 1'b1;
      state_nxt = WARMUP;
      cnt_nxt   = WARM_LAST;
    end else begin
      case (state)
        IDLE: begin
        end
        WARMUP: begin
          adv = 1'b1;
          if (cnt_q == 16'd0) begin
            if (thr_q == 16'd0) begin
              state_nxt = READY;
            end else begin
              state_nxt = SKIP;
              cnt_nxt   = thr_q - 16'd1;
            end
          end else begin
            cnt_nxt = cnt_q - 16'd1;
          end
        end
        SKIP: begin
          adv = 1'b1;
          if (cnt_q == 16'd0) begin
            state_nxt = READY;
          end else begin
            cnt_nxt = cnt_q - 16'd1;
          end
        end
        READY: begin
          if (i_get) begin
            adv  = 1'b1;
            take = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x1_q        <= '0;
      x2_q        <= '0;
      cnt_q       <= '0;
      thr_q       <= '0;
      get_count_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (load) begin
        x1_q        <= 31'd1;
        x2_q        <= i_init;
        thr_q       <= i_threshold;
        get_count_q <= '0;
      end else begin
        if (adv) begin
          x1_q <= x1_ext[30+nGenBit:nGenBit];
          x2_q <= x2_ext[30+nGenBit:nGenBit];
        end
        if (take) begin
          get_count_q <= get_count_q + 16'd1;
        end
      end
    end
  end

  // Word is forced to zero outside READY so nothing stale is presented.
  assign o_valid    = (state == READY);
  assign o_gen_done = (state == READY);
  assign o_gen_bit  = (state == READY) ? (x1_ext[nGenBit-1:0] ^ x2_ext[nGenBit-1:0])
                                       : '0;

endmodule

// File: tb/tb_c_seq_gen_control.sv
// Directed, table-driven bench for c_seq_gen_control with a bit-serial
// Gold-sequence reference model.
module tb_c_seq_gen_control;

  localparam int NG = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic          i_get;
  logic [30:0]   i_init;
  logic [15:0]   i_threshold;
  logic [NG-1:0] o_gen_bit;
  logic          o_valid;
  logic          o_gen_done;

  int n_cmp  = 0;
  int n_fail = 0;

  c_seq_gen_control #(.nGenBit(NG)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_get      (i_get),
    .i_init     (i_init),
    .i_threshold(i_threshold),
    .o_gen_bit  (o_gen_bit),
    .o_valid    (o_valid),
    .o_gen_done (o_gen_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       get;
    logic [7:0] word;
  } vec_t;

  typedef struct {
    logic [30:0] init;
    logic [15:0] thr;
    int          lat;
  } cfg_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bit-serial reference: word idx covers c(NG*idx) .. c(NG*idx+NG-1).
  function automatic logic [NG-1:0] model_word(input logic [30:0] init, input int idx);
    logic [30:0]   x1;
    logic [30:0]   x2;
    logic          n1, n2;
    logic [NG-1:0] w;
    x1 = 31'd1;
    x2 = init;
    for (int s = 0; s < 1600 + NG * idx; s++) begin
      n1 = x1[3] ^ x1[0];
      n2 = x2[3] ^ x2[2] ^ x2[1] ^ x2[0];
      x1 = {n1, x1[30:1]};
      x2 = {n2, x2[30:1]};
    end
    for (int m = 0; m < NG; m++) begin
      w[m] = x1[0] ^ x2[0];
      n1 = x1[3] ^ x1[0];
      n2 = x2[3] ^ x2[2] ^ x2[1] ^ x2[0];
      x1 = {n1, x1[30:1]};
      x2 = {n2, x2[30:1]};
    end
    return w;
  endfunction

  task automatic do_start(input logic [30:0] init, input logic [15:0] thr);
    i_init      = init;
    i_threshold = thr;
    i_start     = 1'b1;
    step();
    i_start     = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_valid && lat < 2000) begin
      step();
      lat++;
    end
  endtask

  task automatic read_vs_model(input string name, input logic [30:0] init,
                               input logic [15:0] thr, input int n);
    i_get = 1'b1;
    for (int k = 0; k < n; k++) begin
      check(name, o_gen_bit, model_word(init, int'(thr) + k));
      step();
    end
    i_get = 1'b0;
  endtask

  initial begin
    vec_t stream[$];
    vec_t pulsed[$];
    cfg_t cfgs[$];
    int   lat;
    logic [7:0] exp_words[14];

    exp_words = '{8'd239, 8'd107, 8'd223, 8'd6, 8'd24, 8'd2, 8'd3,
                  8'd66, 8'd238, 8'd125, 8'd209, 8'd145, 8'd44, 8'd233};
    for (int i = 0; i < 14; i++) stream.push_back('{get: 1'b1, word: exp_words[i]});

    pulsed.push_back('{get: 1'b1, word: 8'd239});
    pulsed.push_back('{get: 1'b1, word: 8'd107});
    for (int i = 0; i < 10; i++) pulsed.push_back('{get: 1'b0, word: 8'd223});
    pulsed.push_back('{get: 1'b1, word: 8'd223});
    pulsed.push_back('{get: 1'b1, word: 8'd6});
    pulsed.push_back('{get: 1'b0, word: 8'd24});

    cfgs.push_back('{init: 31'd512,        thr: 16'd0, lat: 200});
    cfgs.push_back('{init: 31'h1234_5678,  thr: 16'd0, lat: 200});
    cfgs.push_back('{init: 31'h7fff_ffff,  thr: 16'd3, lat: 203});
    cfgs.push_back('{init: 31'd1,          thr: 16'd1, lat: 201});

    rst = 1'b1; i_start = 1'b0; i_get = 1'b0; i_init = '0; i_threshold = '0;

    // reset
    repeat (3) step();
    check("rst_valid", o_valid, 0);
    check("rst_done", o_gen_done, 0);
    check("rst_word", o_gen_bit, 0);
    rst = 1'b0;
    repeat (5) step();
    check("idle_valid", o_valid, 0);
    check("idle_done", o_gen_done, 0);
    check("idle_word", o_gen_bit, 0);

    // c_init=512, threshold=42, continuous read
    do_start(31'd512, 16'd42);
    check("start_valid_low", o_valid, 0);
    wait_valid(lat);
    check("lat_42", lat, 242);
    check("done_42", o_gen_done, 1);
    foreach (stream[i]) begin
      i_get = stream[i].get;
      check($sformatf("stream_word%0d", i), o_gen_bit, stream[i].word);
      check($sformatf("stream_valid%0d", i), o_valid, 1);
      step();
    end
    i_get = 1'b0;

    // pulsed gets with idle gap
    do_start(31'd512, 16'd42);
    wait_valid(lat);
    check("lat_pulsed", lat, 242);
    foreach (pulsed[i]) begin
      i_get = pulsed[i].get;
      check($sformatf("pulsed_word%0d", i), o_gen_bit, pulsed[i].word);
      step();
    end
    i_get = 1'b0;

    // i_get held from start: ignored until READY
    do_start(31'd512, 16'd42);
    i_get = 1'b1;
    wait_valid(lat);
    check("early_get_lat", lat, 242);
    check("early_get_word0", o_gen_bit, 239);
    step();
    check("early_get_word1", o_gen_bit, 107);
    i_get = 1'b0;

    // threshold / c_init sweep against the reference model
    foreach (cfgs[i]) begin
      do_start(cfgs[i].init, cfgs[i].thr);
      wait_valid(lat);
      check($sformatf("cfg%0d_lat", i), lat, cfgs[i].lat);
      read_vs_model($sformatf("cfg%0d_word", i), cfgs[i].init, cfgs[i].thr, 4);
    end

    // restart mid-WARMUP
    do_start(31'd512, 16'd42);
    repeat (50) step();
    do_start(31'h0abc_def1, 16'd5);
    check("restart_warm_valid", o_valid, 0);
    wait_valid(lat);
    check("restart_warm_lat", lat, 205);
    read_vs_model("restart_warm_word", 31'h0abc_def1, 16'd5, 4);

    // restart from READY, with i_get asserted alongside i_start
    i_get = 1'b1;
    do_start(31'h5555_0003, 16'd2);
    i_get = 1'b0;
    check("restart_ready_valid", o_valid, 0);
    check("restart_ready_done", o_gen_done, 0);
    wait_valid(lat);
    check("restart_ready_lat", lat, 202);
    read_vs_model("restart_ready_word", 31'h5555_0003, 16'd2, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
